rs485_uart_tx: RTL
==================

Name: rs485_uart_tx

Overview:
- Serialises command-response bytes onto the RS485 link. It sits directly downstream of the command controller.
- Consumes the `uart_tx_sig` strobe and `uart_tx_data` byte, and returns `uart_idle` as the ready handshake.
- Owns RS485 half-duplex direction control: driver enable, receiver enable, and an optional receive-to-transmit turnaround delay selected by `r2t_delay`.
- Frame format: 8N1, LSB first.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit time (50 MHz / 115200); must be ≥ 2.
- DE_LEAD_BITS, 1, bit times DE is held before the start bit when `r2t_delay`=1; 0 means no lead even if `r2t_delay`=1.
- DE_TAIL_BITS, 1, bit times DE is held after the stop bit; 0 means DE drops right after the stop bit.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_tx_sig  input  1  one-cycle request strobe; honoured only while `uart_idle`=1.
- uart_tx_data  input  8  byte to send; sampled in the cycle `uart_tx_sig`=1.
- r2t_delay  input  1  1 = insert DE lead time before the start bit; sampled at frame accept.
- uart_idle  output  1  1 = ready to accept a byte; registered.
- txd  output  1  serial data to the RS485 transceiver DI pin; idles high.
- de  output  1  transceiver driver enable, active high.
- re_n  output  1  transceiver receiver enable, active low; always equals `de`.
- tx_done  output  1  one-cycle pulse when the frame, including tail, has fully completed.

Behaviour:
- Reset (sync, active-high, overrides all other inputs): state=IDLE, `txd`=1, `de`=0, `re_n`=0, `uart_idle`=1, `tx_done`=0, shift register=0, bit counter=0, baud counter=0.
- States: IDLE → LEAD → START → DATA → STOP → TAIL → IDLE.
- IDLE: `txd`=1, `de`=0, `uart_idle`=1.
  - On `uart_tx_sig`=1, in the same edge: latch `uart_tx_data` into the shift register, latch `r2t_delay`, load the baud counter.
  - Next state is LEAD if latched `r2t_delay`=1 and DE_LEAD_BITS>0, else START.
- Accept cycle N: from cycle N+1, `uart_idle`=0 and `de`=1.
- LEAD: `txd`=1, `de`=1 for DE_LEAD_BITS×CLKS_PER_BIT cycles, then START.
- START: `txd`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. A 3-bit counter stops at 7, then STOP.
- STOP: `txd`=1 for CLKS_PER_BIT cycles. Then TAIL if DE_TAIL_BITS>0, else IDLE.
- TAIL: `txd`=1, `de`=1 for DE_TAIL_BITS×CLKS_PER_BIT cycles, then IDLE.
- On entering IDLE: `tx_done`=1 for exactly that one cycle; `uart_idle`=1 and `de`=0 in the same cycle.
- Frame latency, accept edge to `uart_idle` high: (10 + lead + tail)×CLKS_PER_BIT cycles, where lead = DE_LEAD_BITS if the latched `r2t_delay`=1 (else 0) and tail = DE_TAIL_BITS.
- Baud counter: width = clog2(CLKS_PER_BIT). It counts down from CLKS_PER_BIT−1; its terminal count advances the bit/state. Multi-bit LEAD/TAIL use a separate bit-time counter.
- Request while busy (`uart_idle`=0): ignored, not queued. `uart_tx_data` changes mid-frame have no effect.
- `r2t_delay` toggling mid-frame: no effect on the current frame.
- Back-to-back: a strobe in the `tx_done` cycle is accepted; the next frame's first output cycle follows directly with no gap.
- Reset mid-frame: in the next cycle `txd`=1 and `de`=0; the partial byte is discarded and `tx_done` is not pulsed.
- `txd`, `de` and `re_n` are all registered outputs (glitch-free to the pins).

Decomposition:
- Shared package `rs485_pkg` holds:
  - state encoding constants: IDLE=0, LEAD=1, START=2, DATA=3, STOP=4, TAIL=5 (3 bits);
  - `DATA_BITS`=8;
  - the default CLKS_PER_BIT for the board clock. The matching receiver reuses these.
- One sub-module: `uart_bit_timer`.
  - Parameter CLKS_PER_BIT; inputs `load` and `en`; output `tick` (one-cycle pulse every CLKS_PER_BIT enabled cycles after `load`).
  - Instantiated once for bit timing; LEAD/TAIL multiples are counted in the parent.

Test Plan (CLKS_PER_BIT=4, DE_LEAD_BITS=1, DE_TAIL_BITS=1):
- Reset then hold 20 cycles → `txd`=1, `de`=0, `re_n`=0, `uart_idle`=1, `tx_done`=0 throughout.
- `r2t_delay`=0, strobe 0xF0 → START 0 for 4 cycles, then bits 0,0,0,0,1,1,1,1 at 4 cycles each, stop 1, 4-cycle tail; `de`=1 for 44 cycles; `tx_done` and `uart_idle` rise 44 cycles after the accept edge.
- `r2t_delay`=1, strobe 0xA5 → `de`=1 with `txd`=1 for 4 cycles before the start bit; data bits 1,0,1,0,0,1,0,1; `uart_idle` returns after 48 cycles.
- Strobe 0xFA, then strobe 0xEE 10 cycles later → only 0xFA is serialised; the second strobe is ignored. A new strobe in the `tx_done` cycle is accepted with no idle gap.
- Assert `reset` during DATA bit 3 of 0xFB → next cycle `txd`=1, `de`=0, `uart_idle`=1, no `tx_done`; a following 0xEF frame is sent correctly.
- Toggle `r2t_delay` 0→1 during STOP of a frame → current frame has no lead; the next frame has a 4-cycle lead.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared definitions for the RS485 UART transmitter and matching receiver.
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    TAIL  = 3'd5
  } tx_state_e;

  localparam int unsigned DATA_BITS            = 8;
  // 50 MHz board clock at 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Counter width able to hold values 0..n-1, never narrower than one bit
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time generator: one-cycle tick every CLKS_PER_BIT enabled cycles after load.
module uart_bit_timer
  import rs485_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned     BW     = ctr_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]   RELOAD = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] cnt_q, cnt_d;

  assign tick = en && !load && (cnt_q == '0);

  // Down-counter reloads on load and on every terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - BW'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rs485_uart_tx.sv
// 8N1 LSB-first UART transmitter with RS485 driver/receiver enable control.
module rs485_uart_tx
  import rs485_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DE_LEAD_BITS = 1,
  parameter int unsigned DE_TAIL_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_tx_sig,
  input  logic [7:0] uart_tx_data,
  input  logic       r2t_delay,
  output logic       uart_idle,
  output logic       txd,
  output logic       de,
  output logic       re_n,
  output logic       tx_done
);

  localparam int unsigned   MULT_MAX  = (DE_LEAD_BITS > DE_TAIL_BITS) ? DE_LEAD_BITS : DE_TAIL_BITS;
  localparam int unsigned   MW        = ctr_width(MULT_MAX);
  localparam logic [MW-1:0] LEAD_LAST = MW'(DE_LEAD_BITS - 1);
  localparam logic [MW-1:0] TAIL_LAST = MW'(DE_TAIL_BITS - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e     state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [MW-1:0] mult_cnt_q;
  logic          txd_q;
  logic          de_q;
  logic          idle_q;
  logic          done_q;
  logic          accept;
  logic          bit_tick;

  assign accept    = (state_q == IDLE) && uart_tx_sig;
  assign uart_idle = idle_q;
  assign txd       = txd_q;
  assign de        = de_q;
  // Receiver is disabled exactly while the driver is enabled
  assign re_n      = de_q;
  assign tx_done   = done_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock(clock),
    .reset(reset),
    .load (accept),
    .en   (state_q != IDLE),
    .tick (bit_tick)
  );

  // Frame sequencer; outputs are registered from the next-state decision.
  // r2t_delay only matters in the accept cycle, so it selects LEAD/START
  // directly instead of being held for the whole frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      mult_cnt_q <= '0;
      txd_q      <= 1'b1;
      de_q       <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (uart_tx_sig) begin
            shift_q    <= uart_tx_data;
            bit_cnt_q  <= '0;
            mult_cnt_q <= '0;
            de_q       <= 1'b1;
            idle_q     <= 1'b0;
            if (r2t_delay && (DE_LEAD_BITS != 0)) begin
              state_q <= LEAD;
              txd_q   <= 1'b1;
            end else begin
              state_q <= START;
              txd_q   <= 1'b0;
            end
          end
        end
        LEAD: begin
          if (bit_tick) begin
            if (mult_cnt_q == LEAD_LAST) begin
              mult_cnt_q <= '0;
              state_q    <= START;
              txd_q      <= 1'b0;
            end else begin
              mult_cnt_q <= mult_cnt_q + MW'(1);
            end
          end
        end
        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (DE_TAIL_BITS != 0) begin
              state_q <= TAIL;
            end else begin
              state_q <= IDLE;
              de_q    <= 1'b0;
              idle_q  <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        TAIL: begin
          if (bit_tick) begin
            if (mult_cnt_q == TAIL_LAST) begin
              mult_cnt_q <= '0;
              state_q    <= IDLE;
              de_q       <= 1'b0;
              idle_q     <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              mult_cnt_q <= mult_cnt_q + MW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          de_q    <= 1'b0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
